// File: rtl/mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_arbiter_if
// Bundles the two-port requester handshake and the single-port memory bus
// used by mem_arbiter.
//
// Signals
//   req[1:0]      requester i is asking for the memory
//   we[1:0]       1 = write, 0 = read, per requester (valid while req[i]=1)
//   addr0/addr1   per-requester address
//   wdata0/wdata1 per-requester write data
//   ack[1:0]      one-cycle completion pulse per requester
//   rdata0/rdata1 per-requester read data, valid while the matching ack = 1
//   gnt[1:0]      one-hot owner of the memory, zero when idle
//   mem_read      memory read strobe
//   mem_write     memory write strobe
//   mem_addr      memory address
//   mem_data_in   memory write data
//   mem_data_out  registered memory read data
//
// Modports
//   slave  : the arbiter side
//   master : the requesters plus the memory (the environment around the arbiter)
// ---------------------------------------------------------------------------
interface mem_arbiter_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
);

  logic [1:0]        req;
  logic [1:0]        we;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic [1:0]        ack;
  logic [DATA_W-1:0] rdata0;
  logic [DATA_W-1:0] rdata1;
  logic [1:0]        gnt;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data_in;
  logic [DATA_W-1:0] mem_data_out;

  modport slave (
    input  req, we, addr0, addr1, wdata0, wdata1, mem_data_out,
    output ack, rdata0, rdata1, gnt, mem_read, mem_write, mem_addr, mem_data_in
  );

  modport master (
    output req, we, addr0, addr1, wdata0, wdata1, mem_data_out,
    input  ack, rdata0, rdata1, gnt, mem_read, mem_write, mem_addr, mem_data_in
  );

endinterface

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Two-requester round-robin arbiter in front of a single-port memory with
// registered read data. One transaction is in flight at a time; the owner's
// request (we/addr/wdata) is latched at the granting edge, so the requester
// may change its inputs freely afterwards.
//
// Transaction timing, counted from the granting edge:
//   write : WRITE (mem_write=1) -> ACK               ack in the 2nd cycle
//   read  : READ  (mem_read=1)  -> CAPT -> ACK       ack in the 3rd cycle
// After ACK there is always one IDLE cycle before the next grant.
//
// Ports
//   clk   single clock, all state changes on its rising edge
//   rst_  asynchronous active-low reset; aborts any transaction without ack
//   bus   mem_arbiter_if.slave: requester handshake and memory bus
//
// Every output is driven straight from a register.
// ---------------------------------------------------------------------------
module mem_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input  logic          clk,
  input  logic          rst_,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    READ  = 3'd2,
    CAPT  = 3'd3,
    ACK   = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        gnt_q, gnt_d;
  logic [1:0]        ack_q, ack_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_data_in_q, mem_data_in_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  // Index of the port granted most recently; resets to 1 so that port 0
  // wins the first tie.
  logic              last_gnt_q, last_gnt_d;

  // Port index chosen in IDLE: a lone request wins outright, a tie goes to
  // the port that was not granted last.
  logic              pick;

  // Round-robin selection between the two request lines.
  always_comb begin
    if (bus.req == 2'b11) begin
      pick = ~last_gnt_q;
    end else begin
      pick = bus.req[1];
    end
  end

  // Next-state and output decode. The strobes and ack default to zero so
  // they are high for exactly one cycle in the state that sets them; all
  // other registers hold unless a state explicitly updates them.
  always_comb begin
    state_d       = state_q;
    gnt_d         = gnt_q;
    ack_d         = 2'b00;
    mem_read_d    = 1'b0;
    mem_write_d   = 1'b0;
    mem_addr_d    = mem_addr_q;
    mem_data_in_d = mem_data_in_q;
    rdata0_d      = rdata0_q;
    rdata1_d      = rdata1_q;
    last_gnt_d    = last_gnt_q;

    unique case (state_q)
      IDLE: begin
        if (bus.req != 2'b00) begin
          gnt_d         = pick ? 2'b10 : 2'b01;
          last_gnt_d    = pick;
          mem_addr_d    = pick ? bus.addr1 : bus.addr0;
          mem_data_in_d = pick ? bus.wdata1 : bus.wdata0;
          if (bus.we[pick]) begin
            state_d     = WRITE;
            mem_write_d = 1'b1;
          end else begin
            state_d    = READ;
            mem_read_d = 1'b1;
          end
        end
      end

      WRITE: begin
        state_d = ACK;
        ack_d   = gnt_q;
      end

      // The memory presents its data at the edge ending READ, so it is
      // captured one cycle later, at the edge ending CAPT.
      READ: begin
        state_d = CAPT;
      end

      CAPT: begin
        state_d = ACK;
        ack_d   = gnt_q;
        if (gnt_q[1]) begin
          rdata1_d = bus.mem_data_out;
        end else begin
          rdata0_d = bus.mem_data_out;
        end
      end

      ACK: begin
        state_d = IDLE;
        gnt_d   = 2'b00;
      end

      default: begin
        state_d = IDLE;
        gnt_d   = 2'b00;
      end
    endcase
  end

  // State and output registers; reset takes effect immediately and clears
  // any transaction in progress without acknowledging it.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q       <= IDLE;
      gnt_q         <= 2'b00;
      ack_q         <= 2'b00;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_addr_q    <= '0;
      mem_data_in_q <= '0;
      rdata0_q      <= '0;
      rdata1_q      <= '0;
      last_gnt_q    <= 1'b1;
    end else begin
      state_q       <= state_d;
      gnt_q         <= gnt_d;
      ack_q         <= ack_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      mem_addr_q    <= mem_addr_d;
      mem_data_in_q <= mem_data_in_d;
      rdata0_q      <= rdata0_d;
      rdata1_q      <= rdata1_d;
      last_gnt_q    <= last_gnt_d;
    end
  end

  assign bus.gnt         = gnt_q;
  assign bus.ack         = ack_q;
  assign bus.mem_read    = mem_read_q;
  assign bus.mem_write   = mem_write_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_data_in = mem_data_in_q;
  assign bus.rdata0      = rdata0_q;
  assign bus.rdata1      = rdata1_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
// Drives two requesters and models the external single-port memory around
// mem_arbiter. Stimulus pushes the expected transaction into expQ in grant
// order; the monitor pops it on every ack and compares grant, strobes,
// memory bus values, latency and read data.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 8;

  logic clk = 1'b0;
  logic rst_ = 1'b1;

  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk  (clk),
    .rst_ (rst_),
    .bus  (bus)
  );

  // Requester-side drive variables
  logic              reqP0 = 1'b0, reqP1 = 1'b0;
  logic              weP0 = 1'b0, weP1 = 1'b0;
  logic [ADDR_W-1:0] addrP0 = '0, addrP1 = '0;
  logic [DATA_W-1:0] wdataP0 = '0, wdataP1 = '0;

  assign bus.req    = {reqP1, reqP0};
  assign bus.we     = {weP1, weP0};
  assign bus.addr0  = addrP0;
  assign bus.addr1  = addrP1;
  assign bus.wdata0 = wdataP0;
  assign bus.wdata1 = wdataP1;

  // Memory model: unwritten location a holds 8'h40 + a.
  logic [DATA_W-1:0] memModel [32];
  logic [31:0]       memWritten = '0;
  logic [DATA_W-1:0] memDataOut = '0;

  assign bus.mem_data_out = memDataOut;

  always @(posedge clk) begin
    if (bus.mem_write) begin
      memModel[bus.mem_addr]   <= bus.mem_data_in;
      memWritten[bus.mem_addr] <= 1'b1;
    end
    if (bus.mem_read) begin
      memDataOut <= memWritten[bus.mem_addr] ? memModel[bus.mem_addr]
                                             : DATA_W'(8'h40 + bus.mem_addr);
    end
  end

  // Scoreboard
  typedef struct {
    int port;
    bit isWrite;
    int addr;
    int wdata;
    int rdata;
  } exp_t;

  exp_t expQ[$];
  int   assertCount = 0;
  int   failCount = 0;
  int   cycle = 0;

  always @(posedge clk) cycle++;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic pushExp(input int port, input bit isWrite, input int addr,
                         input int wdata, input int rdata);
    exp_t e;
    e.port = port;
    e.isWrite = isWrite;
    e.addr = addr;
    e.wdata = wdata;
    e.rdata = rdata;
    expQ.push_back(e);
  endtask

  task automatic checkResetState();
    checkOutput("rstAck", bus.ack, 0);
    checkOutput("rstGnt", bus.gnt, 0);
    checkOutput("rstMemRead", bus.mem_read, 0);
    checkOutput("rstMemWrite", bus.mem_write, 0);
    checkOutput("rstMemAddr", bus.mem_addr, 0);
    checkOutput("rstMemDataIn", bus.mem_data_in, 0);
    checkOutput("rstRdata0", bus.rdata0, 0);
    checkOutput("rstRdata1", bus.rdata1, 0);
  endtask

  // Issue one transaction on a port and wait (bounded) for its ack. Req is
  // dropped just after the edge ending ack unless holdReq is set. With
  // scramble set, the port's address and data are inverted once the grant
  // is visible, which must not disturb the latched transaction.
  task automatic applyStimulus(input int port, input bit isWrite, input int addr,
                               input int wdata, input bit holdReq, input bit scramble);
    bit gotAck = 1'b0;
    bit doScramble = scramble;
    if (port == 0) begin
      reqP0 = 1'b1; weP0 = isWrite; addrP0 = addr[ADDR_W-1:0]; wdataP0 = wdata[DATA_W-1:0];
    end else begin
      reqP1 = 1'b1; weP1 = isWrite; addrP1 = addr[ADDR_W-1:0]; wdataP1 = wdata[DATA_W-1:0];
    end
    for (int i = 0; i < 40 && !gotAck; i++) begin
      @(negedge clk);
      if (doScramble && bus.gnt[port]) begin
        doScramble = 1'b0;
        if (port == 0) begin
          addrP0 = ~addrP0; wdataP0 = ~wdataP0; weP0 = ~weP0;
        end else begin
          addrP1 = ~addrP1; wdataP1 = ~wdataP1; weP1 = ~weP1;
        end
      end
      if (bus.ack[port]) gotAck = 1'b1;
    end
    checkOutput("ackArrived", gotAck, 1);
    @(posedge clk);
    #1;
    if (!holdReq) begin
      if (port == 0) reqP0 = 1'b0;
      else reqP1 = 1'b0;
    end
  endtask

  // Monitor: invariants every cycle, grant/strobe/ack checks against the
  // front of the scoreboard queue.
  logic [1:0] prevGnt = 2'b00;
  int         grantCycle = 0;
  int         strobeCount = 0;
  int         rdataShadow [2] = '{0, 0};

  always @(negedge clk) begin : monitor
    exp_t e;
    checkOutput("gntOneHot0", 32'($onehot0(bus.gnt)), 1);
    checkOutput("strobesExclusive", bus.mem_read & bus.mem_write, 0);
    if (!rst_) begin
      prevGnt = 2'b00;
      rdataShadow[0] = 0;
      rdataShadow[1] = 0;
    end else begin
      if (bus.gnt != 2'b00 && prevGnt == 2'b00) begin
        grantCycle = cycle;
        strobeCount = 0;
        if (expQ.size() == 0) checkOutput("unexpectedGrant", bus.gnt, 0);
        else checkOutput("gntOwner", bus.gnt, 32'd1 << expQ[0].port);
      end
      if (bus.mem_read || bus.mem_write) begin
        strobeCount++;
        if (expQ.size() == 0) begin
          checkOutput("unexpectedStrobe", {bus.mem_read, bus.mem_write}, 0);
        end else begin
          checkOutput("strobeIsWrite", bus.mem_write, expQ[0].isWrite);
          checkOutput("strobeCycle", cycle - grantCycle, 0);
          checkOutput("memAddr", bus.mem_addr, expQ[0].addr);
          if (expQ[0].isWrite) checkOutput("memDataIn", bus.mem_data_in, expQ[0].wdata);
        end
      end
      if (bus.ack != 2'b00) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpectedAck", bus.ack, 0);
        end else begin
          e = expQ.pop_front();
          checkOutput("ackOwner", bus.ack, 32'd1 << e.port);
          checkOutput("gntDuringAck", bus.gnt, 32'd1 << e.port);
          checkOutput("ackLatency", cycle - grantCycle + 1, e.isWrite ? 2 : 3);
          checkOutput("strobeCount", strobeCount, 1);
          if (!e.isWrite) rdataShadow[e.port] = e.rdata;
          checkOutput("rdata0", bus.rdata0, rdataShadow[0]);
          checkOutput("rdata1", bus.rdata1, rdataShadow[1]);
        end
      end
      prevGnt = bus.gnt;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit sawRead;
    #1 rst_ = 1'b0;
    repeat (2) @(negedge clk);
    checkResetState();
    rst_ = 1'b1;
    @(negedge clk);

    // Port 0 write, then port 1 reads it back; rdata0 must stay 0.
    pushExp(0, 1, 5, 'hA5, 0);
    applyStimulus(0, 1, 5, 'hA5, 0, 0);
    pushExp(1, 0, 5, 0, 'hA5);
    applyStimulus(1, 0, 5, 0, 0, 0);

    // Top and bottom addresses.
    pushExp(0, 1, 31, 'h3C, 0);
    applyStimulus(0, 1, 31, 'h3C, 0, 0);
    pushExp(0, 0, 31, 0, 'h3C);
    applyStimulus(0, 0, 31, 0, 0, 0);
    pushExp(0, 0, 0, 0, 'h40);
    applyStimulus(0, 0, 0, 0, 0, 0);

    // Inputs changed after the grant must not affect the transaction.
    pushExp(1, 1, 10, 'h77, 0);
    applyStimulus(1, 1, 10, 'h77, 0, 1);
    pushExp(1, 0, 10, 0, 'h77);
    applyStimulus(1, 0, 10, 0, 0, 0);
    pushExp(1, 0, 21, 0, 'h55);
    applyStimulus(1, 0, 21, 0, 0, 0);

    // Fresh reset, then both ports request continuously: 0,1,0,1.
    @(negedge clk);
    rst_ = 1'b0;
    #2;
    checkResetState();
    @(negedge clk);
    rst_ = 1'b1;
    pushExp(0, 1, 1, 'h11, 0);
    pushExp(1, 1, 2, 'h22, 0);
    pushExp(0, 1, 3, 'h33, 0);
    pushExp(1, 1, 4, 'h44, 0);
    fork
      begin
        applyStimulus(0, 1, 1, 'h11, 1, 0);
        applyStimulus(0, 1, 3, 'h33, 0, 0);
      end
      begin
        applyStimulus(1, 1, 2, 'h22, 1, 0);
        applyStimulus(1, 1, 4, 'h44, 0, 0);
      end
    join

    // Reset during READ aborts the read; the re-issued read completes.
    @(negedge clk);
    pushExp(1, 0, 5, 0, 'hA5);
    reqP1 = 1'b1; weP1 = 1'b0; addrP1 = 5'd5;
    sawRead = 1'b0;
    for (int i = 0; i < 10 && !sawRead; i++) begin
      @(negedge clk);
      if (bus.mem_read) sawRead = 1'b1;
    end
    checkOutput("readStateReached", sawRead, 1);
    #2 rst_ = 1'b0;
    #1 checkResetState();
    expQ.delete();
    repeat (2) begin
      @(negedge clk);
      checkOutput("noAckInReset", bus.ack, 0);
    end
    pushExp(1, 0, 5, 0, 'hA5);
    #1 rst_ = 1'b1;
    @(negedge clk);
    checkOutput("firstGrantAfterReset", bus.gnt, 2'b10);
    applyStimulus(1, 0, 5, 0, 0, 0);

    repeat (3) @(negedge clk);
    checkOutput("pendingExpectations", expQ.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 5, memory address width (32 locations).
REQ-002 Parameter DATA_W, default 8, memory data width.
REQ-003 clk  input  1  single clock; all state changes on posedge clk.
REQ-004 rst_  input  1  reset, asynchronous, active-low.
REQ-005 req  input  2  request, bit i per requester port i.
REQ-006 we  input  2  bit i: 1 = write, 0 = read, for port i; valid while req[i]=1.
REQ-007 addr0, addr1  input  ADDR_W each  port address.
REQ-008 wdata0, wdata1  input  DATA_W each  port write data.
REQ-009 ack  output  2  one-cycle completion pulse, bit i per port.
REQ-010 rdata0, rdata1  output  DATA_W each  read data, valid while the matching ack bit = 1.
REQ-011 gnt  output  2  one-hot owner of the memory; 0 when idle.
REQ-012 mem_read, mem_write  output  1 each  memory read/write strobes.
REQ-013 mem_addr  output  ADDR_W  memory address.
REQ-014 mem_data_in  output  DATA_W  memory write data.
REQ-015 mem_data_out  input  DATA_W  memory registered read data (updated at posedge while mem_read=1).

Function
REQ-016 FSM states SHALL be IDLE, WRITE, READ, CAPT, ACK; all outputs registered.
REQ-017 IDLE: with any req bit set at a posedge, the arbiter SHALL grant one port, latch its we/addr/wdata into mem_addr/mem_data_in, set gnt, and go to WRITE (we=1) or READ (we=0).
REQ-018 Arbitration SHALL be round-robin: single request wins; with both set, grant the port not granted last; last-grant register resets to port 1, so port 0 wins the first tie.
REQ-019 WRITE: mem_write=1 for exactly one cycle, then ACK.
REQ-020 READ: mem_read=1 for exactly one cycle, then CAPT.
REQ-021 CAPT: the owner's rdata register SHALL load mem_data_out at the posedge ending CAPT, then ACK.
REQ-022 ACK: ack[owner]=1 for one cycle; gnt clears and the FSM returns to IDLE at the following posedge.
REQ-023 Latency, from the granting edge: write ack in the 2nd cycle, read ack in the 3rd cycle; a new grant is possible at the edge ending the IDLE cycle after ACK.
REQ-024 mem_read and mem_write SHALL never be 1 simultaneously; both SHALL be 0 in IDLE, CAPT and ACK.
REQ-025 Requesters SHALL hold req until ack and drop it at the posedge ending ack; a still-asserted req is treated as a new request.
REQ-026 Changes to the latched port's inputs after the grant SHALL have no effect on the transaction in progress.
REQ-027 rdata of the non-owning port SHALL hold its previous value; rdata is not updated on writes.
REQ-028 Address SHALL pass through unmodified, with no wrap logic; 0 and 2**ADDR_W-1 are both legal.

Reset
REQ-029 rst_=0 SHALL immediately force: state IDLE; ack, gnt, mem_read, mem_write = 0; mem_addr, mem_data_in, rdata0, rdata1 = 0; last-grant = port 1.
REQ-030 Reset during any non-IDLE state SHALL abort the transaction with no ack; the requester must re-issue it.
REQ-031 After rst_ rises, the first grant SHALL occur at the earliest posedge where req is non-zero.

Verification
REQ-032 Port 0 write, addr 5 data 8'hA5 -> mem_write=1 for one cycle with mem_addr=5, mem_data_in=A5; ack[0] in the 2nd cycle after the grant.
REQ-033 Port 1 read, addr 5 after REQ-032 -> mem_read for one cycle; ack[1] in the 3rd cycle with rdata1=8'hA5; rdata0 unchanged.
REQ-034 req=2'b11 held continuously after reset, both ports writing -> grants 0,1,0,1; gnt is always one-hot or zero; no overlapping strobes.
REQ-035 Port 0 write addr 31 data 8'h3C, then read addr 31 and addr 0 -> rdata0=8'h3C, then the addr-0 contents.
REQ-036 rst_ pulsed low during a READ state -> all outputs 0 immediately; no ack; a re-issued read completes normally.
